imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: width of request and memory addresses.
REQ-002 Parameter DATA_WIDTH, default 32: instruction word width.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester read request (bit 0 = requester 0, bit 1 = requester 1).
REQ-006 req_addr  input  2*ADDR_WIDTH  per-requester word address; requester 0 in the low slice.
REQ-007 req_ready  output  2  request accepted this cycle; at most one bit set.
REQ-008 resp_valid  output  2  response available for the corresponding requester; at most one bit set.
REQ-009 resp_data  output  DATA_WIDTH  response instruction word, shared by both requesters.
REQ-010 resp_err  output  1  response is for an out-of-range address; qualified by resp_valid.
REQ-011 resp_ready  input  2  per-requester response acceptance.
REQ-012 mem_addr  output  ADDR_WIDTH  address to the single-port instruction memory.
REQ-013 mem_data  input  DATA_WIDTH  registered memory read data, valid one cycle after the address is presented.
REQ-014 mem_validation  input  1  combinational in-range flag from the memory for the current mem_addr.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, READ, RESP; exactly one state is active.
REQ-017 IDLE, no req_valid set: remain in IDLE; req_ready = 0.
REQ-018 IDLE, any req_valid set:
- Grant exactly one requester g.
- Assert req_ready[g] combinationally in the same cycle.
- Drive mem_addr = req_addr[g].
- Latch g, req_addr[g], and err = !mem_validation.
- Go to READ.
REQ-019 Arbitration is round-robin:
- With both req_valid bits set, grant the requester not granted most recently.
- With one bit set, grant that requester regardless of history.
REQ-020 The last-grant pointer updates only on a grant; after reset it points at requester 1, so requester 0 wins the first tie.
REQ-021 READ: drive mem_addr with the latched address; capture mem_data into the response register, or 0 if err is latched; go to RESP.
REQ-022 RESP:
- Drive resp_valid[g] = 1, resp_data, and resp_err = latched err.
- When resp_ready[g] = 1, go to IDLE next cycle.
- Otherwise hold all response outputs stable.
REQ-023 resp_ready of the non-granted requester is ignored.
REQ-024 No new request is accepted in READ or RESP; req_ready = 0 there.
- Minimum request-to-request spacing is 3 cycles.
- Accept-to-resp_valid latency is exactly 2 cycles.
REQ-025 In RESP and IDLE with no grant, mem_addr holds the last latched address.
REQ-026 resp_valid and req_ready are driven from state; they have no combinational path from resp_ready.
REQ-027 Requesters hold req_valid and req_addr stable until req_ready. A request dropped before grant is not served and not remembered.

Reset
REQ-028 While reset is high at a clock edge, the next state is:
- state = IDLE, req_ready = 0, resp_valid = 0, resp_data = 0, resp_err = 0.
- mem_addr = 0, busy = 0, last-grant pointer = requester 1.
REQ-029 Reset asserted in READ or RESP aborts the in-flight transaction. No response is ever issued for it.
REQ-030 The first grant can occur in the first cycle after reset deasserts.

Verification
REQ-031 Single read: req_valid = 01, addr 5, memory word 5 = 0x00A00093 -> req_ready = 01 the same cycle; resp_valid = 01, resp_data = 0x00A00093, resp_err = 0 two cycles later.
REQ-032 Tie after reset: req_valid = 11, addrs 3/4 held -> requester 0 served first; the next grant goes to requester 1 (addr 4); the following tie grants requester 0.
REQ-033 Out of range: depth 100, requester 1 addr 120 (mem_validation = 0) -> resp_valid = 10, resp_err = 1, resp_data = 0.
REQ-034 Backpressure: resp_ready = 00 for 4 cycles in RESP -> resp_valid/data/err held unchanged; req_ready stays 00 despite a pending req_valid = 10; IDLE is entered the cycle after resp_ready = 01.
REQ-035 Reset mid-operation: reset pulsed in READ -> next cycle all outputs at reset values, no resp_valid for the aborted request; a new request 1 cycle later is granted normally.
REQ-036 Checker throughout: req_ready and resp_valid are one-hot or zero; busy = (state != IDLE).

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter giving two instruction fetch requesters access to one
// single-port instruction memory whose read data is registered (one cycle of latency).
//
// Ports:
//   clock, reset            single clock; synchronous active-high reset
//   req_valid/req_addr      per-requester read request; requester 0 in the low slice
//   req_ready               one-hot (or zero) accept, combinational in IDLE only
//   resp_valid/data/err     response to the granted requester; data and err shared
//   resp_ready              per-requester response acceptance
//   mem_addr/mem_data       memory address out, registered read data in
//   mem_validation          combinational in-range flag for the current mem_addr
//   busy                    high whenever a transaction is in flight
module imem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   output logic [1:0]              req_ready,
   output logic [1:0]              resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_data,
   output logic                    resp_err,
   input  logic [1:0]              resp_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_data,
   input  logic                    mem_validation,
   output logic                    busy
);

   typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

   state_e                  state_q, state_d;
   logic                    last_q, last_d;     // requester granted most recently
   logic                    gnt_q, gnt_d;       // requester owning the transaction
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;

   logic                    grant;
   logic                    gnt_idx;
   logic [ADDR_WIDTH-1:0]   gnt_addr;

   always_comb begin
      grant    = (state_q == StIdle) && (req_valid != 2'b00);
      // On a tie the requester not served last wins; otherwise the only active one.
      gnt_idx  = (req_valid == 2'b11) ? ~last_q : req_valid[1];
      gnt_addr = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];

      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      addr_d      = addr_q;
      err_d       = err_q;
      resp_data_d = resp_data_q;

      unique case (state_q)
         StIdle: begin
            if (grant) begin
               state_d = StRead;
               last_d  = gnt_idx;
               gnt_d   = gnt_idx;
               addr_d  = gnt_addr;
               err_d   = ~mem_validation;
            end
         end
         StRead: begin
            // Memory output for an out-of-range address is meaningless, so it is masked.
            resp_data_d = err_q ? '0 : mem_data;
            state_d     = StResp;
         end
         StResp: begin
            if (resp_ready[gnt_q]) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = grant ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
      resp_valid = (state_q == StResp) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
      resp_err   = (state_q == StResp) && err_q;
      resp_data  = resp_data_q;
      // The address is presented during the grant cycle so data arrives in READ.
      mem_addr   = grant ? gnt_addr : addr_q;
      busy       = (state_q != StIdle);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         gnt_q       <= 1'b0;
         addr_q      <= '0;
         err_q       <= 1'b0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         resp_data_q <= resp_data_d;
      end
   end

endmodule
